fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 107 ++++++++++
 tb/tb_fetch_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch unit: PC sequencer, in-order slot buffer, redirect drain.
// Optional FETCH_BYPASS_EN: forward a RUN response straight to decode when no slot is filled.
module fetch_unit #(
  parameter int              ADDR_W   = 32,
  parameter int              DATA_W   = 32,
  parameter int              DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_en,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {RUN, DRAIN} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [CW-1:0]     outst_q, used_q, outst_d;
  logic [PW-1:0]     alloc_q, fill_q, rd_q;
  logic [DEPTH-1:0]  filled_q, filled_d;
  logic [ADDR_W-1:0] slot_pc_q    [DEPTH];
  logic [DATA_W-1:0] slot_instr_q [DEPTH];

  logic run, head_filled, rsp_ok, grant, fill_en, bypass, transfer;

  assign run         = (state_q == RUN);
  assign head_filled = filled_q[rd_q];
  // Responses with nothing outstanding are protocol errors and are ignored.
  assign rsp_ok      = imem_rvalid && (outst_q != '0);
  assign imem_req    = rst && run && (used_q != CW'(DEPTH)) && !redirect_en;
  assign imem_addr   = pc_q;
  assign grant       = imem_req && imem_gnt;

`ifdef FETCH_BYPASS_EN
  assign bypass = rst && rsp_ok && run && !redirect_en && !head_filled && out_ready;
`else
  assign bypass = 1'b0;
`endif

  assign fill_en   = rsp_ok && run && !redirect_en && !bypass;
  assign out_valid = head_filled || bypass;
  assign transfer  = out_valid && out_ready;
  // With no filled slot the bypassed response belongs to the oldest reserved slot.
  assign out_instr = head_filled ? slot_instr_q[rd_q] : (bypass ? imem_rdata : '0);
  assign out_pc    = head_filled ? slot_pc_q[rd_q] : (bypass ? slot_pc_q[fill_q] : '0);
  assign outst_d   = outst_q + CW'(grant) - CW'(rsp_ok);

  always_comb begin
    filled_d = filled_q;
    if (fill_en) filled_d[fill_q] = 1'b1;
    if (transfer && head_filled) filled_d[rd_q] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= RUN;
      pc_q     <= RESET_PC;
      outst_q  <= '0;
      used_q   <= '0;
      alloc_q  <= '0;
      fill_q   <= '0;
      rd_q     <= '0;
      filled_q <= '0;
    end else begin
      outst_q <= outst_d;
      if (redirect_en) begin
        pc_q     <= redirect_pc;
        used_q   <= '0;
        alloc_q  <= '0;
        fill_q   <= '0;
        rd_q     <= '0;
        filled_q <= '0;
        state_q  <= (outst_d != '0) ? DRAIN : RUN;
      end else begin
        if (grant) begin
          pc_q    <= pc_q + ADDR_W'(1);
          alloc_q <= alloc_q + PW'(1);
        end
        if (fill_en || bypass) fill_q <= fill_q + PW'(1);
        if (transfer) rd_q <= rd_q + PW'(1);
        used_q   <= used_q + CW'(grant) - CW'(transfer);
        filled_q <= filled_d;
        if (!run && (outst_d == '0)) state_q <= RUN;
      end
    end
  end

  // Slot payloads need no reset: out_* are gated by the filled bits.
  always_ff @(posedge clk) begin
    if (grant)   slot_pc_q[alloc_q]   <= pc_q;
    if (fill_en) slot_instr_q[fill_q] <= imem_rdata;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed bench for fetch_unit (ADDR_W=8, DEPTH=4) with a latency-programmable memory.
module tb_fetch_unit;

`ifdef FETCH_BYPASS_EN
  localparam int FIRST = 1;
  localparam logic BYP = 1'b1;
`else
  localparam int FIRST = 2;
  localparam logic BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_en = 1'b0;
  logic [7:0]  redirect_pc = '0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [7:0]  out_pc;

  int n_vec = 0;
  int n_err = 0;
  int lat   = 1;
  int grants;

  logic [2:0] vp;
  logic [7:0] ap [3];

  fetch_unit #(.ADDR_W(8), .DATA_W(32), .DEPTH(4), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [7:0] a);
    return {16'hC0DE, ~a, a};
  endfunction

  // Memory answers each grant exactly lat cycles later, in order.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      vp <= '0;
    end else begin
      vp    <= {vp[1:0], imem_req && imem_gnt};
      ap[0] <= imem_addr;
      ap[1] <= ap[0];
      ap[2] <= ap[1];
    end
  end
  assign imem_rvalid = vp[lat-1];
  assign imem_rdata  = mem(ap[lat-1]);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic hold_reset(input logic g, input logic rdy, input int l);
    rst = 1'b0;
    redirect_en = 1'b0;
    imem_gnt = g;
    out_ready = rdy;
    lat = l;
    step();
    step();
  endtask

  task automatic release_reset();
    rst = 1'b1;
    #1;
  endtask

  initial begin
    // Reset values, with grant and ready high so gating is exercised.
    hold_reset(1'b1, 1'b1, 1);
    chk("rst_req", imem_req, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_instr", out_instr, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_addr", imem_addr, 8'h00);

    // Streaming: one instruction per cycle.
    release_reset();
    chk("first_req", imem_req, 1);
    chk("first_addr", imem_addr, 8'h00);
    for (int n = 1; n <= FIRST + 7; n++) begin
      step();
      if (n >= FIRST) begin
        chk("stream_valid", out_valid, 1);
        chk("stream_pc", out_pc, n - FIRST);
        chk("stream_instr", out_instr, mem(8'(n - FIRST)));
      end
    end

    // Backpressure: buffer fills after DEPTH grants.
    hold_reset(1'b1, 1'b0, 1);
    release_reset();
    grants = 0;
    for (int i = 0; i < 10; i++) begin
      if (imem_req && imem_gnt) grants++;
      step();
    end
    chk("bp_grants", grants, 4);
    chk("bp_req_off", imem_req, 0);
    chk("bp_head_valid", out_valid, 1);
    out_ready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_pc", out_pc, k);
      chk("bp_instr", out_instr, mem(8'(k)));
      step();
    end

    // Redirect with two responses outstanding.
    hold_reset(1'b1, 1'b0, 3);
    release_reset();
    step();
    step();
    imem_gnt = 1'b0;
    redirect_en = 1'b1;
    redirect_pc = 8'h40;
    #1;
    chk("drain_redir_req", imem_req, 0);
    step();
    redirect_en = 1'b0;
    imem_gnt = 1'b1;
    #1;
    chk("drain_req0", imem_req, 0);
    chk("drain_valid0", out_valid, 0);
    step();
    chk("drain_req1", imem_req, 0);
    chk("drain_valid1", out_valid, 0);
    step();
    lat = 1;
    out_ready = 1'b1;
    #1;
    chk("drain_run_req", imem_req, 1);
    chk("drain_run_addr", imem_addr, 8'h40);
    chk("drain_no_stale", out_valid, 0);
    repeat (FIRST) step();
    chk("drain_out_valid", out_valid, 1);
    chk("drain_out_pc", out_pc, 8'h40);
    chk("drain_out_instr", out_instr, mem(8'h40));

    // Redirect coinciding with a transfer and a response.
    hold_reset(1'b1, 1'b1, 1);
    release_reset();
    step();
    step();
    chk("rx_xfer_valid", out_valid && out_ready, 1);
    chk("rx_xfer_pc", out_pc, 8'h00);
    redirect_en = 1'b1;
    redirect_pc = 8'h80;
    #1;
    chk("rx_req_blocked", imem_req, 0);
    step();
    redirect_en = 1'b0;
    #1;
    chk("rx_req", imem_req, 1);
    chk("rx_addr", imem_addr, 8'h80);
    chk("rx_dropped", out_valid, 0);
    repeat (FIRST) step();
    chk("rx_out_pc", out_pc, 8'h80);
    chk("rx_out_instr", out_instr, mem(8'h80));

    // PC wraps from 0xFF to 0x00.
    hold_reset(1'b0, 1'b1, 1);
    release_reset();
    redirect_en = 1'b1;
    redirect_pc = 8'hFF;
    step();
    redirect_en = 1'b0;
    imem_gnt = 1'b1;
    #1;
    chk("wrap_addr_ff", imem_addr, 8'hFF);
    chk("wrap_req", imem_req, 1);
    step();
    chk("wrap_addr_00", imem_addr, 8'h00);
    repeat (FIRST - 1) step();
    chk("wrap_out_ff", out_pc, 8'hFF);
    step();
    chk("wrap_out_00", out_pc, 8'h00);

    // Response latency into an empty buffer.
    hold_reset(1'b1, 1'b1, 1);
    release_reset();
    step();
    imem_gnt = 1'b0;
    #1;
    chk("lat_same_cycle", out_valid, BYP);
    if (BYP) chk("lat_byp_pc", out_pc, 8'h00);
    step();
    chk("lat_next_cycle", out_valid, !BYP);
    if (!BYP) chk("lat_buf_pc", out_pc, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
